matrix_stream_packer: RTL
=========================

Name: matrix_stream_packer

Overview:
- Upstream feeder for the combinational matrix transpose stage.
- Accepts matrix elements one per beat, in row-major order, over a valid/ready stream.
- Assembles them into the packed M*N*DATA_WIDTH vector that the transpose stage consumes, and holds it in an output slot with its own valid/ready handshake.
- Double-buffered (fill buffer plus output slot), so the next matrix loads while the previous one waits for the downstream consumer.

Parameters:
- M, 2: matrix rows.
- N, 2: matrix columns.
- DATA_WIDTH, 8: bits per element.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element this cycle.
- in_data  in  DATA_WIDTH  element value.
- out_valid  out  1  out_mat holds a complete matrix.
- out_ready  in  1  downstream accepts out_mat.
- out_mat  out  M*N*DATA_WIDTH  packed matrix, element (0,0) at the MSBs.
- in_last  in  1  last element of the frame (present only with MSP_LAST_CHECK_EN).
- err_last  out  1  sticky framing error (present only with MSP_LAST_CHECK_EN).

Behaviour:
- Packing layout:
  - Element k = N*i+j (row i, column j) occupies bits [(M*N-k)*DATA_WIDTH-1 : (M*N-k-1)*DATA_WIDTH].
  - This is the same MSB-first row-major layout the transpose stage expects.
- Reset (async assert, sync release):
  - state=FILL, cnt=0, fill buffer=0, out_mat=0, out_valid=0.
  - err_last=0 when the feature is compiled in.
- Element counter cnt: width clog2(M*N) (minimum 1); counts 0..M*N-1, then wraps to 0.
- States:
  - FILL: in_ready=1. An accept (in_valid&&in_ready) writes in_data into element slot cnt and increments cnt.
  - FULL: in_ready=0. Fill buffer holds a complete matrix waiting for the output slot.
- Slot free: slot_free = !out_valid || out_ready.
- Accept of element M*N-1 in FILL:
  - cnt is set to 0.
  - If slot_free: out_mat <= assembled matrix including this element; out_valid<=1; stay in FILL.
  - Else: go to FULL.
- In FULL, when slot_free: out_mat <= fill buffer; out_valid<=1; go to FILL.
- Output handshake: out_valid is cleared on out_valid&&out_ready unless a new matrix loads in the same cycle. A simultaneous load takes priority, so out_valid stays 1.
- Latency: out_valid rises the cycle after the last element is accepted.
- Throughput: one element per cycle, with no bubble between frames, when out_ready is held high.
- Output stability: out_mat is stable while out_valid=1 and out_ready=0.
- Input stalls: in_valid may drop mid-frame; partial contents and cnt are held.
- Reset mid-frame: partial frame discarded; a pending output matrix is discarded.
- M*N==1: every accept completes a frame.

Optional Feature:
- MSP_LAST_CHECK_EN defined: in_last and err_last ports exist.
  - Accept with in_last=1 and cnt!=M*N-1: err_last<=1 (sticky until reset); the partial frame is dropped (cnt<=0, nothing emitted).
  - Accept at cnt==M*N-1 with in_last=0: err_last<=1; the matrix is still emitted normally.
- Not defined: no in_last/err_last ports; frames are delimited purely by cnt.

Decomposition:
- Shared package matrix_pkg holds:
  - localparam MN = M*N.
  - Counter width derivation.
  - Function elem_lsb(k, MN, DATA_WIDTH) returning (MN-k-1)*DATA_WIDTH.
  - FILL/FULL state encoding.
- One natural sub-module: matrix_out_slot, the output register with valid/ready and load-priority. The transpose stage has the same downstream need and reuses it.
- Counter and fill buffer stay inline.

Test Plan:
- M=2,N=2,W=8, out_ready=1: stream 0x11,0x22,0x33,0x44 on consecutive cycles -> out_mat=0x11223344, out_valid=1 exactly one cycle after the 0x44 accept.
- Back-to-back: frames 0x11..0x44 then 0x55..0x88, no gaps, out_ready=1 -> in_ready never drops; out_mat 0x11223344 then 0x55667788 on consecutive frame boundaries.
- Backpressure: out_ready=0 throughout two frames -> first matrix held stable, FULL entered after the 8th element, in_ready=0. Raise out_ready -> second matrix (0x55667788) appears the next cycle, in_ready returns to 1.
- Non-square M=2,N=3,W=4: stream 1..6 -> out_mat=0x123456; feeding it to the transpose stage yields 0x142536.
- Reset mid-frame: accept 0xAA,0xBB, pulse rst_n low -> out_valid=0, out_mat=0. Next four elements 0x01..0x04 -> out_mat=0x01020304.
- MSP_LAST_CHECK_EN: in_last=1 on the 2nd element -> err_last=1, no output. Following well-formed frame 0x01..0x04 -> out_mat=0x01020304, err_last stays 1.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the matrix stream packer and its output slot.
//   - DEF_M / DEF_N / DEF_DW / DEF_MN : default matrix geometry (2x2, 8-bit).
//     Modules derive their own MN = M*N from their parameters.
//   - cnt_width(mn) : element counter width, clog2(mn) with a minimum of 1.
//   - elem_lsb(k, mn, dw) : LSB of element k in the MSB-first row-major
//     packed vector, (mn-k-1)*dw.
//   - msp_state_e : FILL / FULL state encoding of the packer.
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int DEF_M  = 2;
    localparam int DEF_N  = 2;
    localparam int DEF_DW = 8;
    localparam int DEF_MN = DEF_M * DEF_N;

    // FILL: accepting elements into the fill buffer.
    // FULL: fill buffer holds a complete matrix waiting for the output slot.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } msp_state_e;

    function automatic int cnt_width(input int mn);
        return (mn > 1) ? $clog2(mn) : 1;
    endfunction

    // Element (0,0) sits at the MSBs, so element k ends up mn-k-1 slots
    // above bit 0.
    function automatic int elem_lsb(input int k, input int mn, input int dw);
        return (mn - k - 1) * dw;
    endfunction

endpackage : matrix_pkg

// File: rtl/matrix_out_slot.sv
// -----------------------------------------------------------------------------
// matrix_out_slot
//   Single-entry output register with a valid/ready handshake. A load in the
//   same cycle as a downstream transfer wins, so out_valid stays high and the
//   new word replaces the one just taken.
//
// Handshake: a word moves downstream on any rising clk edge where
//   out_valid && out_ready. out_mat is held stable while out_valid=1 and
//   out_ready=0. load must only be asserted when slot_free=1.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write load_data into the slot this cycle
//   load_data   : word to store
//   out_ready   : downstream accepts out_mat
//   out_valid   : slot holds a word
//   out_mat     : stored word (reset value 0, held after it is taken)
//   slot_free   : slot is empty or is being emptied this cycle
// -----------------------------------------------------------------------------
module matrix_out_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_mat,
    output logic         slot_free
);

    logic         valid_q;
    logic [W-1:0] mat_q;

    assign slot_free = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_mat   = mat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mat_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            mat_q   <= load_data;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule : matrix_out_slot

// File: rtl/matrix_stream_packer.sv
// -----------------------------------------------------------------------------
// matrix_stream_packer
//   Collects M*N elements, one per beat in row-major order, into the packed
//   MSB-first vector used by the matrix transpose stage. A fill buffer plus an
//   output slot give double buffering: the next matrix loads while the
//   previous one waits downstream.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready. in_ready depends only on the FSM state, never on in_valid.
//   out_mat is stable while out_valid=1 and out_ready=0.
//
// Build option: define MSP_LAST_CHECK_EN to add in_last / err_last framing
//   checks. Without it, frames are delimited purely by the element counter.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input element valid
//   in_ready   : block can accept an element (state FILL)
//   in_data    : element value
//   out_valid  : out_mat holds a complete matrix
//   out_ready  : downstream accepts out_mat
//   out_mat    : packed matrix, element (0,0) at the MSBs
//   dbg_state  : current FSM state (FILL/FULL)
//   in_last    : last element of frame   (MSP_LAST_CHECK_EN only)
//   err_last   : sticky framing error    (MSP_LAST_CHECK_EN only)
// -----------------------------------------------------------------------------
module matrix_stream_packer
    import matrix_pkg::*;
#(
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [M*N*DATA_WIDTH-1:0] out_mat,
    output msp_state_e                dbg_state
`ifdef MSP_LAST_CHECK_EN
    ,
    input  logic                      in_last,
    output logic                      err_last
`endif
);

    localparam int MN = M * N;
    localparam int CW = cnt_width(MN);
    localparam int VW = MN * DATA_WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(MN - 1);

    msp_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [VW-1:0] fill_q;
    logic [VW-1:0] assembled;
    logic          accept;
    logic          at_last;
    logic          frame_done;
    logic          drop_frame;
    logic          load;
    logic [VW-1:0] load_data;
    logic          slot_free;

    assign in_ready  = (state_q == ST_FILL);
    assign accept    = in_valid && in_ready;
    assign at_last   = (cnt_q == CNT_LAST);
    assign dbg_state = state_q;

`ifdef MSP_LAST_CHECK_EN
    // An early in_last abandons the partial frame; a missing in_last on the
    // final element only raises the error flag.
    assign drop_frame = accept && in_last && !at_last;
`else
    assign drop_frame = 1'b0;
`endif
    assign frame_done = accept && at_last;

    // Fill buffer with the current element merged into slot cnt. This is
    // both the next fill buffer value and, on the final element, the matrix
    // handed straight to the output slot without waiting a cycle.
    always_comb begin
        assembled = fill_q;
        for (int k = 0; k < MN; k++) begin
            if (cnt_q == CW'(k)) begin
                assembled[elem_lsb(k, MN, DATA_WIDTH) +: DATA_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fill_q <= '0;
        end else if (accept) begin
            fill_q <= assembled;
            if (frame_done || drop_frame) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_data = fill_q;
        case (state_q)
            ST_FILL: begin
                if (frame_done) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = assembled;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = fill_q;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    matrix_out_slot #(
        .W(VW)
    ) u_out_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_mat   (out_mat),
        .slot_free (slot_free)
    );

`ifdef MSP_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_last <= 1'b0;
        end else if (accept && (in_last != at_last)) begin
            err_last <= 1'b1;
        end
    end
`endif

endmodule : matrix_stream_packer
